// File: rtl/edge_sched_pkg.sv
// Shared types and helpers for the edge event scheduler: detector state
// encoding, its reset value and the round-robin search.
package edge_sched_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b10,
    SP = 2'b00,
    S1 = 2'b01
  } edge_state_t;

  // Reset into "held high" so a line that is already high never fires.
  localparam edge_state_t EDGE_RST_STATE = S1;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_grant_t;

  // First eligible channel after `last`, wrapping modulo n (n <= 16).
  function automatic rr_grant_t rr_next(input logic [15:0] elig,
                                        input logic [3:0]  last,
                                        input logic [4:0]  n);
    rr_grant_t  g;
    logic [4:0] sum;
    logic [3:0] cand;
    g.valid = 1'b0;
    g.idx   = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      sum  = 5'(last) + 5'(k);
      cand = 4'((sum >= n) ? (sum - n) : sum);
      if (!g.valid && (5'(k) <= n) && elig[cand]) begin
        g.valid = 1'b1;
        g.idx   = cand;
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Three-state Moore rising-edge detector; pulse is high for exactly the
// one cycle the machine spends in SP.
module edge_detect
  import edge_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  edge_state_t state;

  // Detector state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EDGE_RST_STATE;
    end else begin
      case (state)
        S0:      state <= in ? SP : S0;
        SP:      state <= in ? S1 : S0;
        S1:      state <= in ? S1 : S0;
        default: state <= in ? S1 : S0;
      endcase
    end
  end

  assign pulse = (state == SP);

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel rising-edge scheduler: per-channel detectors feed saturating
// pending counters, drained round-robin onto one valid/ready event port.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int CNT_W = 4,
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N-1:0]    overflow,
  output logic            busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [N-1:0]     pulse;
  logic [N-1:0]     dec;
  logic [N-1:0]     elig;
  logic [CNT_W-1:0] cnt [N];
  logic [ID_W-1:0]  last;
  logic             hs;
  rr_grant_t        grant;

  for (genvar i = 0; i < N; i++) begin : g_det
    edge_detect u_det (
      .clk   (clk),
      .rst   (rst),
      .in    (in[i]),
      .pulse (pulse[i])
    );
  end

  // Handshake decode and eligibility; the accepted channel is judged on cnt-1
  always_comb begin
    hs   = evt_valid && evt_ready;
    dec  = '0;
    elig = '0;
    for (int i = 0; i < N; i++) begin
      dec[i]  = hs && (evt_id == ID_W'(i));
      elig[i] = dec[i] ? (cnt[i] > CNT_ONE) : (cnt[i] != '0);
    end
    grant = rr_next(16'(elig), 4'(last), 5'(N));
  end

  // Busy while anything is pending or offered
  always_comb begin
    busy = evt_valid;
    for (int i = 0; i < N; i++) begin
      busy = busy | (cnt[i] != '0);
    end
  end

  // Pending counters with saturation and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pulse[i] && !dec[i]) begin
          if (cnt[i] == CNT_MAX) begin
            overflow[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end else if (dec[i] && !pulse[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end else begin
          cnt[i] <= cnt[i];
        end
      end
    end
  end

  // Output register: reload when empty or on handshake, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      last      <= ID_W'(N - 1);
    end else if (!evt_valid || hs) begin
      evt_valid <= grant.valid;
      if (grant.valid) begin
        evt_id <= ID_W'(grant.idx);
        last   <= ID_W'(grant.idx);
      end else begin
        evt_id <= evt_id;
        last   <= last;
      end
    end else begin
      evt_valid <= evt_valid;
      evt_id    <= evt_id;
      last      <= last;
    end
  end

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler (N=4, CNT_W=2 so saturation is
// reachable quickly); expected values are hand-derived cycle by cycle.
module tb_edge_event_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] overflow;
  logic       busy;

  int errors = 0;
  int checks = 0;

  edge_event_scheduler #(.N(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] id);
    chk({tag, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) chk({tag, "_id"}, 32'(evt_id), 32'(id));
  endtask

  initial begin
    rst = 1'b1; in = 4'b0010; evt_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 1: line high through reset release must stay silent
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_hold_valid", 32'(evt_valid), 32'd0);
      chk("t1_hold_busy", 32'(busy), 32'd0);
    end
    in = 4'b0000; step();
    in = 4'b0010; step();
    chk_evt("t1_k", 1'b0, 2'd0);
    step();
    chk_evt("t1_k1", 1'b0, 2'd0);
    chk("t1_k1_busy", 32'(busy), 32'd1);
    step();
    chk_evt("t1_k2", 1'b1, 2'd1);
    evt_ready = 1'b1; step();
    chk_evt("t1_done", 1'b0, 2'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);
    in = 4'b0000; step(); step();

    // 2: single edge on ch2, offered for one cycle
    in = 4'b0100; step();
    step();
    chk_evt("t2_k1", 1'b0, 2'd0);
    chk("t2_k1_busy", 32'(busy), 32'd1);
    step();
    chk_evt("t2_k2", 1'b1, 2'd2);
    step();
    chk_evt("t2_k3", 1'b0, 2'd0);
    chk("t2_k3_busy", 32'(busy), 32'd0);
    in = 4'b0000; step(); step();

    // 3: simultaneous edges on ch0/1/3 after reset
    rst = 1'b1; step();
    rst = 1'b0; step();
    in = 4'b1011; step();
    step();
    step();
    chk_evt("t3_g0", 1'b1, 2'd0);
    step();
    chk_evt("t3_g1", 1'b1, 2'd1);
    step();
    chk_evt("t3_g3", 1'b1, 2'd3);
    step();
    chk_evt("t3_end", 1'b0, 2'd0);
    chk("t3_end_busy", 32'(busy), 32'd0);
    in = 4'b0000; step();

    // 4: backpressure on ch2 while ch0 edges twice
    evt_ready = 1'b0;
    in = 4'b0100; step(); step(); step();
    chk_evt("t4_offer", 1'b1, 2'd2);
    in = 4'b0101; step(); chk_evt("t4_hold1", 1'b1, 2'd2);
    in = 4'b0100; step(); chk_evt("t4_hold2", 1'b1, 2'd2);
    in = 4'b0101; step(); chk_evt("t4_hold3", 1'b1, 2'd2);
    in = 4'b0100; step(); chk_evt("t4_hold4", 1'b1, 2'd2);
    step();               chk_evt("t4_hold5", 1'b1, 2'd2);
    evt_ready = 1'b1;
    step(); chk_evt("t4_g0a", 1'b1, 2'd0);
    step(); chk_evt("t4_g0b", 1'b1, 2'd0);
    step(); chk_evt("t4_end", 1'b0, 2'd0);
    in = 4'b0000; step();

    // 5: four edges on ch1 saturate the 2-bit counter
    evt_ready = 1'b0;
    for (int e = 0; e < 4; e++) begin
      in = 4'b0010; step();
      if (e == 3) chk("t5_ovf_pre", 32'(overflow), 32'd0);
      in = 4'b0000; step();
    end
    chk("t5_ovf", 32'(overflow), 32'b0010);
    chk_evt("t5_offer", 1'b1, 2'd1);
    evt_ready = 1'b1;
    step(); chk_evt("t5_g2", 1'b1, 2'd1);
    step(); chk_evt("t5_g3", 1'b1, 2'd1);
    step(); chk_evt("t5_end", 1'b0, 2'd0);
    step(); chk_evt("t5_end2", 1'b0, 2'd0);
    chk("t5_ovf_sticky", 32'(overflow), 32'b0010);

    // 6: reset while an event is offered and counters are nonzero
    evt_ready = 1'b0;
    in = 4'b1001; step();
    in = 4'b0000; step();
    step();
    chk_evt("t6_offer", 1'b1, 2'd3);
    chk("t6_busy", 32'(busy), 32'd1);
    rst = 1'b1; evt_ready = 1'b1; step();
    rst = 1'b0;
    chk("t6_valid", 32'(evt_valid), 32'd0);
    chk("t6_id", 32'(evt_id), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_busy0", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_quiet_valid", 32'(evt_valid), 32'd0);
      chk("t6_quiet_busy", 32'(busy), 32'd0);
    end
    in = 4'b0001; step(); step(); step();
    chk_evt("t6_new", 1'b1, 2'd0);
    step();
    chk_evt("t6_new_done", 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
